// File: rtl/booth_product_accumulator.sv
// booth_product_accumulator
//   Sums N_TERMS signed products from the Booth multiplier into a signed
//   saturating accumulator and presents one result per window.
//
//   Ports
//     clk        in   rising-edge clock
//     reset      in   asynchronous active-low reset
//     in_valid   in   in_prdt valid this cycle
//     in_ready   out  product can be accepted this cycle (state only)
//     in_prdt    in   signed product, PW bits
//     clear      in   synchronous abort of the partial window
//     out_valid  out  out_sum/out_sat hold a completed window
//     out_ready  in   consumer takes the result this cycle
//     out_sum    out  signed saturated window sum, AW bits
//     out_sat    out  saturation occurred at least once in the window
//     term_cnt   out  products accepted in the current window
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   IDLE  | single cycle after reset release, nothing accepted
//   ACC   | accepting products into the running sum
//   HOLD  | completed window presented, waiting for out_ready
module booth_product_accumulator #(
    parameter int PW      = 16,
    parameter int AW      = 24,
    parameter int N_TERMS = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [PW-1:0] in_prdt,
    input  logic          clear,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [AW-1:0] out_sum,
    output logic          out_sat,
    output logic [7:0]    term_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    localparam logic [AW-1:0] SUM_MAX  = {1'b0, {(AW-1){1'b1}}};
    localparam logic [AW-1:0] SUM_MIN  = {1'b1, {(AW-1){1'b0}}};
    localparam logic [7:0]    LAST_CNT = 8'(N_TERMS - 1);

    state_t        state_q, state_d;
    logic [AW-1:0] acc_q, acc_d;
    logic [7:0]    cnt_q, cnt_d;
    logic          sticky_q, sticky_d;
    logic          out_valid_q, out_valid_d;
    logic [AW-1:0] out_sum_q, out_sum_d;
    logic          out_sat_q, out_sat_d;

    logic [AW-1:0] prdt_ext;
    logic [AW-1:0] raw_sum;
    logic [AW-1:0] sat_sum;
    logic          ovf;
    logic          accept;
    logic          last_term;

    assign prdt_ext = {{(AW-PW){in_prdt[PW-1]}}, in_prdt};
    assign raw_sum  = acc_q + prdt_ext;

    // Signed overflow: both operands share a sign that the result lost.
    // The clamp direction follows the operand sign.
    assign ovf     = (acc_q[AW-1] == prdt_ext[AW-1]) && (raw_sum[AW-1] != acc_q[AW-1]);
    assign sat_sum = !ovf ? raw_sum : (acc_q[AW-1] ? SUM_MIN : SUM_MAX);

    assign in_ready  = (state_q == ST_ACC);
    assign accept    = in_valid && in_ready;
    assign last_term = (cnt_q == LAST_CNT);

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        sticky_d    = sticky_q;
        out_valid_d = out_valid_q;
        out_sum_d   = out_sum_q;
        out_sat_d   = out_sat_q;

        case (state_q)
            ST_IDLE: begin
                state_d = ST_ACC;
            end
            ST_ACC: begin
                if (clear) begin
                    // Clear beats any simultaneous accept, including the last term.
                    acc_d    = '0;
                    cnt_d    = '0;
                    sticky_d = 1'b0;
                end else if (accept) begin
                    if (last_term) begin
                        out_sum_d   = sat_sum;
                        out_sat_d   = sticky_q | ovf;
                        out_valid_d = 1'b1;
                        acc_d       = '0;
                        cnt_d       = '0;
                        sticky_d    = 1'b0;
                        state_d     = ST_HOLD;
                    end else begin
                        acc_d    = sat_sum;
                        cnt_d    = cnt_q + 8'd1;
                        sticky_d = sticky_q | ovf;
                    end
                end
            end
            ST_HOLD: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = ST_ACC;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
            sticky_q    <= 1'b0;
            out_valid_q <= 1'b0;
            out_sum_q   <= '0;
            out_sat_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            sticky_q    <= sticky_d;
            out_valid_q <= out_valid_d;
            out_sum_q   <= out_sum_d;
            out_sat_q   <= out_sat_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_sum   = out_sum_q;
    assign out_sat   = out_sat_q;
    assign term_cnt  = cnt_q;

endmodule

// File: tb/tb_booth_product_accumulator.sv
// tb_booth_product_accumulator
//   Directed bench: instance A (N_TERMS=8, AW=17) and instance B
//   (N_TERMS=4, AW=24) share clock and reset; each has its own handshake.
module tb_booth_product_accumulator;

    logic clk;
    logic rst_n;

    logic        a_valid, a_iready, a_clear, a_ovalid, a_oready, a_sat;
    logic [15:0] a_prdt;
    logic [16:0] a_sum;
    logic [7:0]  a_cnt;

    logic        b_valid, b_iready, b_clear, b_ovalid, b_oready, b_sat;
    logic [15:0] b_prdt;
    logic [23:0] b_sum;
    logic [7:0]  b_cnt;

    int n_assert = 0;
    int n_fail   = 0;

    booth_product_accumulator #(.PW(16), .AW(17), .N_TERMS(8)) u_a (
        .clk(clk), .reset(rst_n),
        .in_valid(a_valid), .in_ready(a_iready), .in_prdt(a_prdt), .clear(a_clear),
        .out_valid(a_ovalid), .out_ready(a_oready), .out_sum(a_sum), .out_sat(a_sat),
        .term_cnt(a_cnt)
    );

    booth_product_accumulator #(.PW(16), .AW(24), .N_TERMS(4)) u_b (
        .clk(clk), .reset(rst_n),
        .in_valid(b_valid), .in_ready(b_iready), .in_prdt(b_prdt), .clear(b_clear),
        .out_valid(b_ovalid), .out_ready(b_oready), .out_sum(b_sum), .out_sat(b_sat),
        .term_cnt(b_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one product to A and hold it until accepted, bounded.
    task automatic a_accept(input logic [15:0] p);
        bit done;
        done    = 0;
        a_valid = 1'b1;
        a_prdt  = p;
        for (int i = 0; i < 50 && !done; i++) begin
            if (a_iready) done = 1;
            tick();
        end
        a_valid = 1'b0;
        if (!done) chk("a_accept_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        int vals[4];
        int macc, mcnt, windows, cycles, p, s, exp_sum;
        bit m_hold, m_sticky, o, new_win, exp_sat;

        rst_n = 1'b0;
        a_valid = 0; a_prdt = '0; a_clear = 0; a_oready = 1;
        b_valid = 0; b_prdt = '0; b_clear = 0; b_oready = 1;

        // Reset state
        #3;
        chk("rst_a_iready", 32'(a_iready), 32'd0);
        chk("rst_a_ovalid", 32'(a_ovalid), 32'd0);
        chk("rst_a_sum",    32'(a_sum),    32'd0);
        chk("rst_a_cnt",    32'(a_cnt),    32'd0);
        chk("rst_b_iready", 32'(b_iready), 32'd0);
        tick(); tick();
        rst_n = 1'b1;
        chk("idle_a_iready", 32'(a_iready), 32'd0);
        tick();
        chk("acc_a_iready", 32'(a_iready), 32'd1);
        chk("acc_b_iready", 32'(b_iready), 32'd1);

        // Test 1: B, N=4, 100,-50,25,-75 back-to-back
        vals = '{100, -50, 25, -75};
        for (int i = 0; i < 4; i++) begin
            chk("t1_iready", 32'(b_iready), 32'd1);
            b_valid = 1'b1;
            b_prdt  = 16'(vals[i]);
            tick();
            if (i == 0) chk("t1_cnt1", 32'(b_cnt), 32'd1);
            if (i < 3)  chk("t1_noval", 32'(b_ovalid), 32'd0);
        end
        b_valid = 1'b0;
        chk("t1_ovalid", 32'(b_ovalid), 32'd1);
        chk("t1_sum",    32'($signed(b_sum)), 32'd0);
        chk("t1_sat",    32'(b_sat), 32'd0);
        chk("t1_cnt0",   32'(b_cnt), 32'd0);
        tick();
        chk("t1_ovalid_drop", 32'(b_ovalid), 32'd0);

        // Test 2: A, AW=17, eight 0x7FFF then eight 0x8000
        for (int i = 0; i < 8; i++) begin
            a_accept(16'h7FFF);
            if (i == 1) begin
                chk("t2_cnt2",   32'(a_cnt), 32'd2);
                chk("t2_noval",  32'(a_ovalid), 32'd0);
            end
        end
        chk("t2_pos_ovalid", 32'(a_ovalid), 32'd1);
        chk("t2_pos_sum",    32'($signed(a_sum)), 32'd65535);
        chk("t2_pos_sat",    32'(a_sat), 32'd1);
        for (int i = 0; i < 8; i++) a_accept(16'h8000);
        chk("t2_neg_ovalid", 32'(a_ovalid), 32'd1);
        chk("t2_neg_sum",    32'($signed(a_sum)), 32'hFFFF_0000);
        chk("t2_neg_sat",    32'(a_sat), 32'd1);
        tick();
        chk("t2_ovalid_drop", 32'(a_ovalid), 32'd0);

        // Test 3: backpressure
        a_oready = 1'b0;
        for (int i = 0; i < 8; i++) a_accept(16'd5);
        a_valid = 1'b1;
        a_prdt  = 16'd7;
        chk("t3_sum0", 32'($signed(a_sum)), 32'd40);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t3_iready", 32'(a_iready), 32'd0);
            chk("t3_ovalid", 32'(a_ovalid), 32'd1);
            chk("t3_sum",    32'($signed(a_sum)), 32'd40);
            chk("t3_cnt",    32'(a_cnt), 32'd0);
        end
        a_oready = 1'b1;
        tick();
        chk("t3_hs_ovalid", 32'(a_ovalid), 32'd0);
        chk("t3_hs_cnt",    32'(a_cnt), 32'd0);
        chk("t3_hs_iready", 32'(a_iready), 32'd1);
        tick();
        chk("t3_first_acc", 32'(a_cnt), 32'd1);
        a_valid = 1'b0;

        // Test 4: clear
        a_clear = 1'b1;
        tick();
        a_clear = 1'b0;
        chk("t4_clr_cnt", 32'(a_cnt), 32'd0);
        a_accept(16'd10); a_accept(16'd20); a_accept(16'd30);
        chk("t4_cnt3", 32'(a_cnt), 32'd3);
        a_valid = 1'b1; a_prdt = 16'd99; a_clear = 1'b1;
        tick();
        a_valid = 1'b0; a_clear = 1'b0;
        chk("t4_clr_drop", 32'(a_cnt), 32'd0);
        chk("t4_clr_state", 32'(a_iready), 32'd1);
        for (int i = 0; i < 8; i++) a_accept(16'd1);
        chk("t4_ovalid", 32'(a_ovalid), 32'd1);
        chk("t4_sum",    32'($signed(a_sum)), 32'd8);
        chk("t4_sat",    32'(a_sat), 32'd0);
        for (int i = 0; i < 7; i++) a_accept(16'd1);
        chk("t4_cnt7",   32'(a_cnt), 32'd7);
        a_valid = 1'b1; a_prdt = 16'd1; a_clear = 1'b1;
        tick();
        a_valid = 1'b0; a_clear = 1'b0;
        chk("t4_clr_nth_ovalid", 32'(a_ovalid), 32'd0);
        chk("t4_clr_nth_cnt",    32'(a_cnt), 32'd0);
        tick();
        chk("t4_clr_nth_ovalid2", 32'(a_ovalid), 32'd0);
        a_oready = 1'b0;
        for (int i = 0; i < 8; i++) a_accept(16'd2);
        a_clear = 1'b1;
        tick();
        a_clear = 1'b0;
        chk("t4_hold_clr_ovalid", 32'(a_ovalid), 32'd1);
        chk("t4_hold_clr_sum",    32'($signed(a_sum)), 32'd16);
        a_oready = 1'b1;
        tick();
        chk("t4_hold_clr_hs", 32'(a_ovalid), 32'd0);

        // Test 5: async reset mid-window (A) and mid-HOLD (B)
        a_accept(16'd3); a_accept(16'd3); a_accept(16'd3);
        b_oready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            b_valid = 1'b1; b_prdt = 16'd9;
            tick();
        end
        b_valid = 1'b0;
        chk("t5_b_hold", 32'(b_ovalid), 32'd1);
        chk("t5_a_cnt3", 32'(a_cnt), 32'd3);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("t5_a_cnt",    32'(a_cnt),    32'd0);
        chk("t5_a_iready", 32'(a_iready), 32'd0);
        chk("t5_b_ovalid", 32'(b_ovalid), 32'd0);
        chk("t5_b_sum",    32'(b_sum),    32'd0);
        chk("t5_b_sat",    32'(b_sat),    32'd0);
        b_oready = 1'b1;
        tick();
        rst_n = 1'b1;
        chk("t5_idle_iready", 32'(a_iready), 32'd0);
        tick();
        chk("t5_acc_a_iready", 32'(a_iready), 32'd1);
        chk("t5_acc_b_iready", 32'(b_iready), 32'd1);

        // Test 6: random traffic on A against an integer clamping model
        macc = 0; mcnt = 0; windows = 0; cycles = 0;
        m_hold = 0; m_sticky = 0; exp_sum = 0; exp_sat = 0;
        while (windows < 1000 && cycles < 60000) begin
            chk("rnd_iready", 32'(a_iready), 32'(!m_hold));
            a_valid  = 1'($urandom_range(0, 1));
            a_prdt   = 16'($urandom);
            a_oready = 1'($urandom_range(0, 1));
            new_win  = 0;
            if (!m_hold && a_valid) begin
                p = int'($signed(a_prdt));
                s = macc + p;
                o = 0;
                if (s > 65535)  begin s = 65535;  o = 1; end
                if (s < -65536) begin s = -65536; o = 1; end
                mcnt++;
                if (mcnt == 8) begin
                    exp_sum  = s;
                    exp_sat  = m_sticky | o;
                    m_hold   = 1;
                    macc     = 0;
                    mcnt     = 0;
                    m_sticky = 0;
                    windows++;
                    new_win  = 1;
                end else begin
                    macc     = s;
                    m_sticky = m_sticky | o;
                end
            end else if (m_hold && a_oready) begin
                m_hold = 0;
            end
            tick();
            cycles++;
            chk("rnd_ovalid", 32'(a_ovalid), 32'(m_hold));
            chk("rnd_cnt",    32'(a_cnt),    32'(mcnt));
            if (new_win) begin
                chk("rnd_sum", 32'($signed(a_sum)), 32'(exp_sum));
                chk("rnd_sat", 32'(a_sat),          32'(exp_sat));
            end
        end
        a_valid = 1'b0;
        chk("rnd_windows", 32'(windows), 32'd1000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
